compl1_reg: RTL and testbench
=============================

// Module: compl1_reg
// PURPOSE
//   Registered, parameterised one's-complement stage for the ALU datapath.
//   When cpl=1 the output is the bitwise inverse of the input; when cpl=0 the
//   input passes through unchanged. Results leave through a fixed-latency
//   valid-tagged pipeline and carry zero, negative-zero and sign flags.
//   Sits ahead of the adder in the ALU, supplying the B operand for subtraction.
// PARAMETERS
//   WIDTH   4   operand width in bits (>=2)
//   STAGES  1   pipeline latency in clock cycles (>=1)
// PORTS
//   clk        in   1      single clock; all state updates on the rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      ent/cpl are valid this cycle
//   ent        in   WIDTH  operand
//   cpl        in   1      1 = complement, 0 = pass through
//   out_valid  out  1      sal and flags hold a new result this cycle
//   sal        out  WIDTH  result: cpl ? ~ent : ent
//   zero       out  1      sal == all zeros
//   neg_zero   out  1      sal == all ones (one's-complement negative zero)
//   sign       out  1      sal[WIDTH-1]
// BEHAVIOUR
//   - Function: sal = cpl ? ~ent : ent, bit for bit. There is no carry and
//     no end-around add. Width is preserved.
//   - Pipeline: STAGES register stages. Each stage has a valid bit, a data
//     field and three flag bits. Flags are computed combinationally from the
//     stage-1 result and travel with it.
//   - Valid bits shift one stage every cycle. A stage's data and flags load
//     only when the valid bit entering that stage is 1. Otherwise they hold.
//     As a result, the outputs keep the last valid result through bubbles.
//   - Latency: an input accepted at edge N (in_valid=1) appears with
//     out_valid=1 after edge N+STAGES-1. With STAGES=1, it is visible in the
//     cycle after the capturing edge.
//   - Throughput: one result per cycle. There is no backpressure, and
//     out_valid is a single-cycle pulse per accepted input.
//   - Reset: on any edge with rst=1, all valid bits, data and flags clear to 0.
//     This gives out_valid=0, sal=0, zero=0, neg_zero=0, sign=0. The zero flag
//     also reads 0 after reset; it is only meaningful while out_valid=1.
//   - rst has priority over in_valid in the same cycle; that input is dropped.
//   - Reset asserted mid-operation discards every in-flight result. No
//     out_valid is produced for those results after reset.
//   - Boundaries:
//     - ent=0 with cpl=1 gives all ones, neg_zero=1, sign=1.
//     - ent=all ones with cpl=1 gives 0, zero=1.
//     - zero and neg_zero are never both 1 (WIDTH>=2).
//   - Inputs are sampled only when in_valid=1; X on ent/cpl is don't-care
//     otherwise.
// TESTING
//   1. WIDTH=4, STAGES=1: ent=0101, cpl=0, in_valid=1 -> next cycle
//      out_valid=1, sal=0101, sign=0, zero=0, neg_zero=0.
//   2. ent=0101, cpl=1 -> sal=1010, sign=1, zero=0, neg_zero=0.
//   3. ent=0000, cpl=1 -> sal=1111, neg_zero=1. Then ent=1111, cpl=1 ->
//      sal=0000, zero=1.
//   4. Back-to-back inputs 0011/c0, 0011/c1, 1000/c1 over 3 cycles ->
//      sal 0011, 1100, 0111 on consecutive cycles with out_valid high
//      throughout. An idle cycle follows: out_valid=0, sal holds 0111.
//   5. STAGES=3: a single input at edge N appears only after edge N+2.
//      Asserting rst at edge N+1 yields no out_valid and sal=0.
//   6. rst=1 and in_valid=1 in the same cycle -> input dropped; out_valid
//      stays 0 next cycle and all outputs are 0.

Source files
------------

// File: rtl/compl1_reg.sv
// compl1_reg: registered one's-complement stage with a fixed-latency,
// valid-tagged pipeline carrying zero, negative-zero and sign flags.
// Supplies the B operand (optionally inverted) to the ALU adder.
module compl1_reg #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] ent,
    input  logic             cpl,
    output logic             out_valid,
    output logic [WIDTH-1:0] sal,
    output logic             zero,
    output logic             neg_zero,
    output logic             sign
);

    // Flag bit positions within each stage's flag field.
    localparam int unsigned F_ZERO = 2;
    localparam int unsigned F_NEGZ = 1;
    localparam int unsigned F_SIGN = 0;

    logic [WIDTH-1:0] result;
    logic [2:0]       result_flags;

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] dat;
    logic [STAGES-1:0][2:0]       flg;

    // Stage-1 result and its flags; flags then travel with the data.
    always_comb begin
        result                       = cpl ? ~ent : ent;
        result_flags                 = '0;
        result_flags[F_ZERO]         = (result == '0);
        result_flags[F_NEGZ]         = (result == '1);
        result_flags[F_SIGN]         = result[WIDTH-1];
    end

    // First stage: valid follows in_valid; payload loads only on a valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld[0] <= 1'b0;
            dat[0] <= '0;
            flg[0] <= '0;
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                dat[0] <= result;
                flg[0] <= result_flags;
            end
        end
    end

    // Later stages: valid shifts every cycle; payload loads only behind a valid,
    // so the output holds the last valid result through bubbles.
    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                vld[g] <= 1'b0;
                dat[g] <= '0;
                flg[g] <= '0;
            end else begin
                vld[g] <= vld[g-1];
                if (vld[g-1]) begin
                    dat[g] <= dat[g-1];
                    flg[g] <= flg[g-1];
                end
            end
        end
    end

    assign out_valid = vld[STAGES-1];
    assign sal       = dat[STAGES-1];
    assign zero      = flg[STAGES-1][F_ZERO];
    assign neg_zero  = flg[STAGES-1][F_NEGZ];
    assign sign      = flg[STAGES-1][F_SIGN];

endmodule

// File: tb/tb_compl1_reg.sv
// Testbench for compl1_reg: two instances (STAGES=1 and STAGES=3, WIDTH=4)
// driven by the same directed and random stimulus, compared with a model
// built from a per-edge input history.
module tb_compl1_reg;

    localparam int MAXC = 2048;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] ent;
    logic       cpl;

    logic       ov1, z1, nz1, s1;
    logic [3:0] sal1;
    logic       ov3, z3, nz3, s3;
    logic [3:0] sal3;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    // Per-edge history of what the DUTs sampled.
    bit       h_rst [MAXC];
    bit       h_v   [MAXC];
    bit [3:0] h_e   [MAXC];
    bit       h_c   [MAXC];

    // Held model outputs per instance (0: STAGES=1, 1: STAGES=3).
    logic [3:0] held_sal [2];
    logic [2:0] held_f   [2];

    always #5 clk = ~clk;

    compl1_reg #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ent(ent), .cpl(cpl),
        .out_valid(ov1), .sal(sal1), .zero(z1), .neg_zero(nz1), .sign(s1)
    );

    compl1_reg #(.WIDTH(4), .STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ent(ent), .cpl(cpl),
        .out_valid(ov3), .sal(sal3), .zero(z3), .neg_zero(nz3), .sign(s3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, got[7:0], exp[7:0]);
        end
    endtask

    // Expected {out_valid, sal, zero, neg_zero, sign} right after edge cyc:
    // the input taken at edge cyc-lat+1 emerges unless any reset hit it since.
    task automatic model(input int idx, input int lat, output logic [7:0] expv);
        int         e;
        bit         fire;
        logic [3:0] val;
        e    = cyc - lat + 1;
        fire = (e >= 0) && h_v[e];
        if (e >= 0)
            for (int k = e; k <= cyc; k++)
                if (h_rst[k]) fire = 0;
        if (h_rst[cyc]) begin
            held_sal[idx] = '0;
            held_f[idx]   = '0;
        end else if (fire) begin
            val           = h_c[e] ? ~h_e[e] : h_e[e];
            held_sal[idx] = val;
            held_f[idx]   = {val == 4'h0, val == 4'hF, val[3]};
        end
        expv = {fire, held_sal[idx], held_f[idx]};
    endtask

    // Drive one cycle of inputs, record them at the edge, then compare both DUTs.
    task automatic step(input bit r, input bit v, input logic [3:0] e, input bit c);
        logic [7:0] x1, x3;
        @(negedge clk);
        rst = r; in_valid = v; ent = e; cpl = c;
        @(posedge clk);
        h_rst[cyc] = r; h_v[cyc] = v; h_e[cyc] = e; h_c[cyc] = c;
        #1;
        model(0, 1, x1);
        model(1, 3, x3);
        check("model_s1", {24'd0, ov1, sal1, z1, nz1, s1}, {24'd0, x1});
        check("model_s3", {24'd0, ov3, sal3, z3, nz3, s3}, {24'd0, x3});
        cyc++;
    endtask

    function automatic logic [31:0] v1();
        return {24'd0, ov1, sal1, z1, nz1, s1};
    endfunction

    function automatic logic [31:0] v3();
        return {24'd0, ov3, sal3, z3, nz3, s3};
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; ent = '0; cpl = 1'b0;
        held_sal[0] = '0; held_sal[1] = '0; held_f[0] = '0; held_f[1] = '0;

        repeat (3) step(1, 0, 4'h0, 0);
        check("reset_s1", v1(), 32'h0);
        check("reset_s3", v3(), 32'h0);

        // Pass-through, complement, and the all-zero / all-one boundaries.
        step(0, 1, 4'b0101, 0); check("pass_0101", v1(), {24'd0, 8'b1_0101_000});
        step(0, 1, 4'b0101, 1); check("cpl_0101",  v1(), {24'd0, 8'b1_1010_001});
        step(0, 1, 4'b0000, 1); check("cpl_0000",  v1(), {24'd0, 8'b1_1111_011});
        step(0, 1, 4'b1111, 1); check("cpl_1111",  v1(), {24'd0, 8'b1_0000_100});

        // Back-to-back then an idle cycle that holds the last result.
        step(0, 1, 4'b0011, 0); check("b2b_a", v1(), {24'd0, 8'b1_0011_000});
        step(0, 1, 4'b0011, 1); check("b2b_b", v1(), {24'd0, 8'b1_1100_001});
        step(0, 1, 4'b1000, 1); check("b2b_c", v1(), {24'd0, 8'b1_0111_000});
        step(0, 0, 4'b0000, 0); check("idle_hold", v1(), {24'd0, 8'b0_0111_000});
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);

        // Three-stage latency: visible only after edge N+2.
        step(0, 1, 4'b0110, 1); check("lat3_n",  {31'd0, ov3}, 32'd0);
        step(0, 0, 4'b0000, 0); check("lat3_n1", {31'd0, ov3}, 32'd0);
        step(0, 0, 4'b0000, 0); check("lat3_n2", v3(), {24'd0, 8'b1_1001_001});
        step(0, 0, 4'b0000, 0); check("lat3_hold", v3(), {24'd0, 8'b0_1001_001});

        // Reset mid-flight in the three-stage pipe discards the result.
        step(0, 1, 4'b0001, 0);
        step(1, 0, 4'b0000, 0); check("midrst_s3", v3(), 32'h0);
        step(0, 0, 4'b0000, 0); check("midrst_s3_a", v3(), 32'h0);
        step(0, 0, 4'b0000, 0); check("midrst_s3_b", v3(), 32'h0);

        // Reset wins over a simultaneous valid input.
        step(1, 1, 4'b1010, 1); check("rstprio_s1", v1(), 32'h0);
        check("rstprio_s3", v3(), 32'h0);
        step(0, 0, 4'b0000, 0); check("rstprio_s1_next", v1(), 32'h0);
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0); check("rstprio_s3_late", v3(), 32'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tests++;
            if ((z1 && nz1) || (z3 && nz3)) begin
                failed++;
                $display("FAIL flags_exclusive cyc=%0d z1=%b nz1=%b z3=%b nz3=%b", cyc, z1, nz1, z3, nz3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
